// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size and state encodings for the RAM load/store bridge
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW     = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane extraction with sign/zero extension, sub-word store merge and misalignment check
//   word_i     : RAM word being read or merged into
//   lane_i     : byte lane (address bits [1:0])
//   size_i     : access size encoding (SZ_B / SZ_H / SZ_W, 2'b11 illegal)
//   uns_i      : zero-extend loads when 1
//   wdata_i    : right-aligned store data (only the low half-word is ever merged)
//   ldata_o    : extended load result
//   mdata_o    : word_i with the store data merged into the addressed lane
//   misalign_o : illegal size or lane not aligned to the access size
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] ldata_o,
    output logic [31:0] mdata_o,
    output logic        misalign_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word_i[{lane_i, 3'b000} +: 8];
        h = word_i[{lane_i[1], 4'b0000} +: 16];
        ldata_o = size_i == SZ_B ? {{24{b[7] & ~uns_i}}, b}
                : size_i == SZ_H ? {{16{h[15] & ~uns_i}}, h}
                : word_i;
        mdata_o = word_i;
        if (size_i == SZ_B)
            mdata_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        else if (size_i == SZ_H)
            mdata_o[{lane_i[1], 4'b0000} +: 16] = wdata_i;
        misalign_o = size_i == 2'b11
                  || (size_i == SZ_H && lane_i[0])
                  || (size_i == SZ_W && lane_i != 2'b00);
    end

endmodule

// File: rtl/ram_lsu_bridge.sv
// ram_lsu_bridge: RISC-V byte-addressed load/store front end for a word-wide, byte-enable-less RAM
//   clk, rstn          : clock, synchronous active-low reset
//   req_*              : request handshake (valid/ready), store flag, byte address, size, unsigned, store data
//   rsp_*              : one-cycle response pulse with load data and error flag
//   ram_wen/w_addr/w_data : RAM write port
//   ram_ren/r_addr/r_data : RAM read port, data returned one cycle after ram_ren
module ram_lsu_bridge
    import lsu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_ren,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q, size_q;
    logic          uns_q;
    logic [15:0]   wdata_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [DW-1:0] rsp_rdata_q;

    logic          idle, accept, misalign, do_sw, do_rd;
    logic [AW-1:0] req_idx;
    logic [1:0]    al_lane, al_size;
    logic [DW-1:0] ldata, mdata;

    // Upper address bits fall away in the mask, so addresses wrap modulo 4*DEPTH.
    assign req_idx = AW'((req_addr >> 2) & (DEPTH - 1));

    assign idle      = state_q == IDLE;
    assign req_ready = idle;
    assign accept    = req_valid && idle;

    // The aligner checks the live request while idle and works on the captured one afterwards.
    assign al_lane = idle ? req_addr[1:0] : lane_q;
    assign al_size = idle ? req_size : size_q;

    lsu_align u_align (
        .word_i     (ram_r_data),
        .lane_i     (al_lane),
        .size_i     (al_size),
        .uns_i      (uns_q),
        .wdata_i    (wdata_q),
        .ldata_o    (ldata),
        .mdata_o    (mdata),
        .misalign_o (misalign)
    );

    assign do_sw = accept && !misalign && req_we && req_size == SZ_W;
    assign do_rd = accept && !misalign && !do_sw;

    always_comb begin
        state_d = state_q;
        if (idle) begin
            if (accept)
                state_d = (misalign || do_sw) ? RESP : req_we ? RMW : RD_WAIT;
        end else begin
            state_d = state_q == RESP ? IDLE : RESP;
        end
    end

    // RAM strobes are gated by rstn so a reset mid-RMW never reaches the array.
    assign ram_wen    = rstn && (do_sw || state_q == RMW);
    assign ram_w_addr = !ram_wen ? '0 : state_q == RMW ? idx_q : req_idx;
    assign ram_w_data = !ram_wen ? '0 : state_q == RMW ? mdata : req_wdata;
    assign ram_ren    = rstn && do_rd;
    assign ram_r_addr = ram_ren ? req_idx : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= state_d == RESP;
            rsp_err_q   <= accept && misalign;
            rsp_rdata_q <= state_q == RD_WAIT ? ldata : '0;
            if (accept) begin
                idx_q   <= req_idx;
                lane_q  <= req_addr[1:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata[15:0];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
